// File: rtl/lsu_load_ctrl_pkg.sv
// Shared load-side definitions: dtype encodings, exception causes, FSM state codes.
// Also hosts the alignment rule so the controller and any future users agree on it.
package lsu_load_ctrl_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam int ECAUSE_LD_MISALIGNED   = 4;
  localparam int ECAUSE_LD_ACCESS_FAULT = 5;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  typedef struct packed {
    logic       uns;
    logic [1:0] size;
  } dtype_t;

  // A load is misaligned when its byte offset is not a multiple of its size.
  function automatic logic ld_misaligned(input logic [1:0] size, input logic [2:0] off);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_H:    mis = off[0];
      SZ_W:    mis = |off[1:0];
      SZ_D:    mis = |off;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_ctrl_align_ext.sv
// Byte-lane extraction and sign/zero extension of a cache doubleword; purely
// combinational, no latency, no flow control.
module lsu_load_ctrl_align_ext
  import lsu_load_ctrl_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] i_dword,
  input  logic [2:0]        i_off,
  input  dtype_t            i_dtype,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] w_shift;
  logic              w_sx;

  assign w_shift = i_dword >> {i_off, 3'b000};
  assign w_sx    = ~i_dtype.uns;

  always_comb begin
    o_data = w_shift;
    case (i_dtype.size)
      SZ_B:    o_data = {{(DATA_W-8){w_sx & w_shift[7]}},   w_shift[7:0]};
      SZ_H:    o_data = {{(DATA_W-16){w_sx & w_shift[15]}}, w_shift[15:0]};
      SZ_W:    o_data = {{(DATA_W-32){w_sx & w_shift[31]}}, w_shift[31:0]};
      default: o_data = w_shift;
    endcase
  end

endmodule

// File: rtl/lsu_load_ctrl.sv
// One-at-a-time load controller: alignment check, doubleword cache read, extract/extend.
// Aligned load done 3 cycles after request with zero-wait cache; misaligned in 1; killed loads drain.
module lsu_load_ctrl
  import lsu_load_ctrl_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int ECAUSE_W   = 6,
  parameter int ORDERTAG_W = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  input  logic                  i_req_killed,
  input  logic [2:0]            i_req_dtype,
  input  logic [DATA_W-1:0]     i_req_vaddr,
  input  logic [ORDERTAG_W-1:0] i_req_ordertag,
  output logic                  o_resp_ready,
  output logic                  o_resp_done,
  output logic [DATA_W-1:0]     o_resp_data,
  output logic                  o_resp_exc,
  output logic [ECAUSE_W-1:0]   o_resp_ecause,
  output logic                  o_dc_req_valid,
  input  logic                  i_dc_req_ready,
  output logic [DATA_W-1:0]     o_dc_req_addr,
  output logic [ORDERTAG_W-1:0] o_dc_req_tag,
  input  logic                  i_dc_resp_valid,
  input  logic [DATA_W-1:0]     i_dc_resp_data,
  input  logic                  i_dc_resp_err
);

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic [2:0]            r_off;
  dtype_t                r_dtype;
  logic [DATA_W-1:0]     r_addr;
  logic [ORDERTAG_W-1:0] r_tag;
  logic [DATA_W-1:0]     r_data;
  logic                  r_exc;
  logic [ECAUSE_W-1:0]   r_ecause;

  dtype_t                w_req_dtype;
  logic                  w_accept;
  logic                  w_misaligned;
  logic                  w_resp_cap;
  logic                  w_done;
  logic [DATA_W-1:0]     w_ext;

  assign w_req_dtype  = dtype_t'(i_req_dtype);
  assign w_accept     = (r_state == ST_IDLE) && i_req_valid && !i_req_killed;
  assign w_misaligned = ld_misaligned(w_req_dtype.size, i_req_vaddr[2:0]);
  assign w_resp_cap   = (r_state == ST_WAIT) && i_dc_resp_valid;

  lsu_load_ctrl_align_ext #(
    .DATA_W (DATA_W)
  ) u_align_ext (
    .i_dword (i_dc_resp_data),
    .i_off   (r_off),
    .i_dtype (r_dtype),
    .o_data  (w_ext)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept)
          w_state_nxt = w_misaligned ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        // A kill racing the cache handshake still leaves a response to swallow.
        if (i_req_killed)
          w_state_nxt = i_dc_req_ready ? ST_DRAIN : ST_IDLE;
        else if (i_dc_req_ready)
          w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_req_killed)
          w_state_nxt = i_dc_resp_valid ? ST_IDLE : ST_DRAIN;
        else if (i_dc_resp_valid)
          w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      ST_DRAIN: begin
        if (i_dc_resp_valid)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_off    <= '0;
      r_dtype  <= '0;
      r_addr   <= '0;
      r_tag    <= '0;
      r_data   <= '0;
      r_exc    <= 1'b0;
      r_ecause <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_off    <= i_req_vaddr[2:0];
        r_dtype  <= w_req_dtype;
        r_addr   <= {i_req_vaddr[DATA_W-1:3], 3'b000};
        r_tag    <= i_req_ordertag;
        r_data   <= '0;
        r_exc    <= w_misaligned;
        r_ecause <= w_misaligned ? ECAUSE_W'(ECAUSE_LD_MISALIGNED) : '0;
      end
      if (w_resp_cap) begin
        r_data   <= i_dc_resp_err ? '0 : w_ext;
        r_exc    <= i_dc_resp_err;
        r_ecause <= i_dc_resp_err ? ECAUSE_W'(ECAUSE_LD_ACCESS_FAULT) : '0;
      end
    end
  end

  // Result fields are forced to zero outside the single done cycle.
  assign w_done         = (r_state == ST_DONE) && !i_req_killed;
  assign o_resp_done    = w_done;
  assign o_resp_ready   = w_done;
  assign o_resp_data    = w_done ? r_data   : '0;
  assign o_resp_exc     = w_done ? r_exc    : 1'b0;
  assign o_resp_ecause  = w_done ? r_ecause : '0;
  assign o_dc_req_valid = (r_state == ST_ISSUE);
  assign o_dc_req_addr  = r_addr;
  assign o_dc_req_tag   = r_tag;

endmodule
